// File: rtl/fuzz_out_signature_pkg.sv
// Shared types and helpers for the fuzz output signature checker.
// Holds the capture FSM states, the default widths and the vector fold.
package fuzz_sig_pkg;

  localparam int DATA_W = 330;
  localparam int SIG_W = 32;
  localparam logic [SIG_W-1:0] POLY_D = 32'h04C11DB7;
  localparam int N_CHUNK = (DATA_W + SIG_W - 1) / SIG_W;

  typedef enum logic [1:0] {
    IDLE,
    SKIP,
    CAPTURE,
    DONE
  } sig_state_t;

  // XOR of SIG_W-wide slices, lowest slice first, top slice zero-padded
  function automatic logic [SIG_W-1:0] fold_vec(
    input logic [DATA_W-1:0] d
  );
    logic [N_CHUNK*SIG_W-1:0] pad;
    logic [SIG_W-1:0] acc;
    pad = '0;
    pad[DATA_W-1:0] = d;
    acc = '0;
    for (int i = 0; i < N_CHUNK; i++) begin
      acc = acc ^ pad[i*SIG_W +: SIG_W];
    end
    return acc;
  endfunction

endpackage

// File: rtl/fuzz_out_signature_if.sv
// Control and data bundle between the fuzz harness and the signature checker.
// The harness side is master; the checker is slave.
interface fuzz_out_signature_if #(
  parameter int CNT_W = 32
);
  import fuzz_sig_pkg::*;

  logic              start;
  logic              abort;
  logic [CNT_W-1:0]  num_beats;
  logic [DATA_W-1:0] data_in;
  logic              data_valid;
  logic [SIG_W-1:0]  expected_sig;
  logic              busy;
  logic              done;
  logic [SIG_W-1:0]  signature;
  logic              match;
  logic [CNT_W-1:0]  beats_seen;

  modport master (
    output start,
    output abort,
    output num_beats,
    output data_in,
    output data_valid,
    output expected_sig,
    input  busy,
    input  done,
    input  signature,
    input  match,
    input  beats_seen
  );

  modport slave (
    input  start,
    input  abort,
    input  num_beats,
    input  data_in,
    input  data_valid,
    input  expected_sig,
    output busy,
    output done,
    output signature,
    output match,
    output beats_seen
  );

endinterface

// File: rtl/fuzz_out_signature_misr_step.sv
// One combinational MISR step: shift, conditional polynomial feedback, fold in.
// Kept standalone so upstream generator checks can reuse it.
module misr_step #(
  parameter int SIG_W = 32,
  parameter logic [SIG_W-1:0] POLY = 32'h04C11DB7
) (
  input  logic [SIG_W-1:0] sig,
  input  logic [SIG_W-1:0] fold,
  output logic [SIG_W-1:0] sig_next
);

  logic [SIG_W-1:0] fb;

  always_comb begin
    fb = sig[SIG_W-1] ? POLY : '0;
    sig_next = {sig[SIG_W-2:0], 1'b0} ^ fb ^ fold;
  end

endmodule

// File: rtl/fuzz_out_signature.sv
// Compacts valid output beats of the fuzz DUT into a MISR signature
// over a programmed window, then compares against a golden value.
module fuzz_out_signature
  import fuzz_sig_pkg::*;
#(
  parameter logic [SIG_W-1:0] POLY = POLY_D,
  parameter int SKIP_BEATS = 2,
  parameter int CNT_W = 32
) (
  input logic clk,
  input logic rst,
  fuzz_out_signature_if.slave bus
);

  localparam logic [CNT_W-1:0] SKIP_N = CNT_W'(SKIP_BEATS);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  sig_state_t       state;
  logic [CNT_W-1:0] skip_cnt;
  logic [CNT_W-1:0] num_lat;
  logic [CNT_W-1:0] beats;
  logic [SIG_W-1:0] sig;
  logic             busy_q;
  logic             done_q;
  logic             match_q;

  logic [SIG_W-1:0] fold;
  logic [SIG_W-1:0] sig_next;
  logic [CNT_W-1:0] skip_inc;
  logic [CNT_W-1:0] beat_inc;

  always_comb begin
    fold = fold_vec(bus.data_in);
    skip_inc = skip_cnt + ONE;
    beat_inc = beats + ONE;
  end

  misr_step #(
    .SIG_W(SIG_W),
    .POLY (POLY)
  ) u_step (
    .sig     (sig),
    .fold    (fold),
    .sig_next(sig_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      skip_cnt <= '0;
      num_lat  <= '0;
      beats    <= '0;
      sig      <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      match_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      // abort outranks everything but reset, and is a no-op in IDLE
      if (bus.abort && state != IDLE) begin
        state  <= IDLE;
        busy_q <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (bus.start && !bus.abort) begin
              sig      <= '1;
              beats    <= '0;
              match_q  <= 1'b0;
              skip_cnt <= '0;
              num_lat  <= bus.num_beats;
              if (SKIP_BEATS > 0) begin
                state  <= SKIP;
                busy_q <= 1'b1;
              end else if (bus.num_beats == '0) begin
                state  <= DONE;
                done_q <= 1'b1;
              end else begin
                state  <= CAPTURE;
                busy_q <= 1'b1;
              end
            end
          end
          SKIP: begin
            if (bus.data_valid) begin
              skip_cnt <= skip_inc;
              if (skip_inc == SKIP_N) begin
                if (num_lat == '0) begin
                  state  <= DONE;
                  busy_q <= 1'b0;
                  done_q <= 1'b1;
                end else begin
                  state <= CAPTURE;
                end
              end
            end
          end
          CAPTURE: begin
            if (bus.data_valid) begin
              sig   <= sig_next;
              beats <= beat_inc;
              if (beat_inc == num_lat) begin
                state  <= DONE;
                busy_q <= 1'b0;
                done_q <= 1'b1;
              end
            end
          end
          DONE: begin
            match_q <= (sig == bus.expected_sig);
            state   <= IDLE;
          end
        endcase
      end
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.signature  = sig;
  assign bus.match      = match_q;
  assign bus.beats_seen = beats;

endmodule
